// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One shift-and-correct iteration per clock; start/busy/done handshake.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]        state, state_nx;
  logic [WORK_W-1:0] work, work_nx, work_step;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [BIN_W-1:0]  bin_nx;
  logic              busy_nx, done_nx, err_nx;
  logic              bad_digit;

  // Any nibble above 9 makes the request invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One iteration: shift right, then pull 3 out of every BCD field that reached 8.
  always_comb begin
    work_step = work >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_step[BIN_W + 4*d +: 4] >= 4'd8)
        work_step[BIN_W + 4*d +: 4] = work_step[BIN_W + 4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    bin_nx   = bin_out;
    err_nx   = err;
    busy_nx  = busy;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          if (bad_digit) begin
            bin_nx  = '0;
            err_nx  = 1'b1;
            done_nx = 1'b1;
          end else begin
            work_nx  = {bcd_in, {BIN_W{1'b0}}};
            cnt_nx   = CNT_W'(BIN_W);
            err_nx   = 1'b0;
            busy_nx  = 1'b1;
            state_nx = S_CONV;
          end
        end
      end
      S_CONV: begin
        work_nx = work_step;
        cnt_nx  = cnt - CNT_W'(1);
        busy_nx = 1'b1;
        if (cnt == CNT_W'(1)) begin
          bin_nx   = work_step[BIN_W-1:0];
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      work    <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      work    <= work_nx;
      cnt     <= cnt_nx;
      bin_out <= bin_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: cycle-level behavioural model plus directed
// literal checks, exhaustive 2-digit sweep, random traffic and a 3-digit instance.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic [6:0] bin_out;
  logic       busy, done, err;

  logic        start3 = 1'b0;
  logic [11:0] bcd3 = 12'h000;
  logic [9:0]  bin3;
  logic        busy3, done3, err3;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut (
    .clk(clk), .resetn(resetn), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .busy(busy), .done(done), .err(err)
  );

  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .bcd_in(bcd3),
    .bin_out(bin3), .busy(busy3), .done(done3), .err(err3)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [15:0] v, input int nd);
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_val(input logic [15:0] v, input int nd);
    int s = 0;
    int w = 1;
    for (int i = 0; i < nd; i++) begin
      s += int'(v[4*i +: 4]) * w;
      w *= 10;
    end
    return s;
  endfunction

  // Behavioural model: a request either fails at once or completes BIN_W cycles later.
  int m_left = 0;
  int m_bin = 0;
  int m_pend = 0;
  bit m_err = 1'b0, m_done = 1'b0, m_busy = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left = 0; m_bin = 0; m_pend = 0;
      m_err = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_bin  = m_pend;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        if (!bcd_ok(16'(bcd_in), 2)) begin
          m_bin  = 0;
          m_err  = 1'b1;
          m_done = 1'b1;
        end else begin
          m_pend = bcd_val(16'(bcd_in), 2);
          m_err  = 1'b0;
          m_left = 7;
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("bin_out", int'(bin_out), m_bin);
      check("err", int'(err), int'(m_err));
      check("done_and_busy", int'(done & busy), 0);
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic conv(input logic [7:0] v, input int exp_bin, input int exp_err,
                      input int exp_lat, input string nm);
    int cyc;
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check({nm, "_lat"}, cyc, exp_lat);
    check({nm, "_bin"}, int'(bin_out), exp_bin);
    check({nm, "_err"}, int'(err), exp_err);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic conv3(input logic [11:0] v, input int exp_bin, input string nm);
    int cyc = 0;
    @(negedge clk);
    bcd3   = v;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    while (!done3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_lat"}, cyc, 10);
    check({nm, "_bin"}, int'(bin3), exp_bin);
    check({nm, "_err"}, int'(err3), 0);
  endtask

  initial begin
    int cyc;
    int n;
    #1 resetn = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bin", int'(bin_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    #2 resetn = 1'b1;

    conv(8'h99, 99, 0, 7, "c99");
    conv(8'h42, 42, 0, 7, "c42");
    conv(8'h00, 0, 0, 7, "c00");
    conv(8'h07, 7, 0, 7, "c07");
    conv(8'h1A, 0, 1, 0, "c1A");
    conv(8'h10, 10, 0, 7, "c10");

    // Second request while busy must be dropped.
    @(negedge clk);
    bcd_in = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bcd_in = 8'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("ign_bin", int'(bin_out), 55);
    count_dones(12, n);
    check("ign_extra_done", n, 0);

    // Reset mid-conversion aborts it.
    @(negedge clk);
    bcd_in = 8'h88; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("abort_bin", int'(bin_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    count_dones(10, n);
    check("abort_no_done", n, 0);
    conv(8'h31, 31, 0, 7, "c31");

    // Back-to-back with start held high.
    @(negedge clk);
    bcd_in = 8'h25; start = 1'b1;
    wait_done(cyc);
    check("b2b_first_bin", int'(bin_out), 25);
    bcd_in = 8'h26;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_gap", cyc + 1, 8);
    check("b2b_second_bin", int'(bin_out), 26);

    for (int t = 0; t < 100; t++)
      conv(8'((t / 10) * 16 + (t % 10)), t, 0, 7, "sweep");

    // Random traffic, including invalid nibbles and starts while busy.
    repeat (400) begin
      @(negedge clk);
      bcd_in = 8'($urandom);
      start  = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    conv3(12'h999, 999, "d3_999");
    conv3(12'h000, 0, "d3_000");
    repeat (20) begin
      int a, b, c;
      a = $urandom_range(0, 9);
      b = $urandom_range(0, 9);
      c = $urandom_range(0, 9);
      conv3({4'(a), 4'(b), 4'(c)}, a * 100 + b * 10 + c, "d3_rand");
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
